mdrain: RTL and testbench

- Read-side partner to the FFT metadata store.
- Captures per-sample metadata at the FFT input into a two-bank (ping-pong) buffer, one frame of N entries per bank.
- Re-attaches that metadata, in order, to FFT output samples as they emerge, and flags the first sample of each frame.
- Sits between the FFT core output and downstream consumers; one frame can fill while the previous frame drains.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/mdrain_ptr.sv | 32 +++
 rtl/mdrain.sv | 91 +++++++++
 tb/tb_mdrain.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT helpers: clog2, width-parameterised bit reversal and bank-state constants.
package fft_pkg;

  localparam logic BANK_EMPTY = 1'b0;
  localparam logic BANK_FULL  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mdrain_ptr.sv
// Frame pointer: LOG_N-bit address plus bank bit; wraps to the other bank after N advances.
module mdrain_ptr
  import fft_pkg::*;
#(
  parameter int N     = 8,
  parameter int LOG_N = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [LOG_N-1:0] addr,
  output logic             bank,
  output logic             wrap
);

  assign wrap = advance && (addr == LOG_N'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      bank <= 1'b0;
    end else if (advance) begin
      if (wrap) begin
        addr <= '0;
        bank <= ~bank;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdrain.sv
// Ping-pong metadata buffer that re-attaches captured metadata to FFT output samples.
// Define MDRAIN_BITREV_EN to read each frame in bit-reversed address order.
module mdrain
  import fft_pkg::*;
#(
  parameter int N      = 8,
  parameter int MWIDTH = 1,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_nd,
  input  logic [MWIDTH-1:0] in_m,
  input  logic              in_data_nd,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_nd,
  output logic [WIDTH-1:0]  out_data,
  output logic [MWIDTH-1:0] out_m,
  output logic              out_first,
  output logic              error
);

  localparam int LOG_N = clog2(N);

  logic [MWIDTH-1:0] ram [0:2*N-1];
  logic [1:0]        full;
  logic [LOG_N-1:0]  w_addr, r_addr, raddr;
  logic              w_bank, r_bank, w_wrap, r_wrap;
  logic              wr_ok, rd_ok;

  // Each side only touches a bank whose full flag says it owns it.
  assign wr_ok = in_nd      && (full[w_bank] == BANK_EMPTY);
  assign rd_ok = in_data_nd && (full[r_bank] == BANK_FULL);

`ifdef MDRAIN_BITREV_EN
  assign raddr = LOG_N'(bitrev(32'(r_addr), LOG_N));
`else
  assign raddr = r_addr;
`endif

  mdrain_ptr #(.N(N), .LOG_N(LOG_N)) u_wptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (wr_ok),
    .addr    (w_addr),
    .bank    (w_bank),
    .wrap    (w_wrap)
  );

  mdrain_ptr #(.N(N), .LOG_N(LOG_N)) u_rptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (rd_ok),
    .addr    (r_addr),
    .bank    (r_bank),
    .wrap    (r_wrap)
  );

  always_ff @(posedge clk) begin
    if (wr_ok) ram[{w_bank, w_addr}] <= in_m;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (w_wrap) full[w_bank] <= BANK_FULL;
      if (r_wrap) full[r_bank] <= BANK_EMPTY;
    end
  end

  // Output stage: one cycle behind in_data_nd
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_nd    <= 1'b0;
      out_data  <= '0;
      out_m     <= '0;
      out_first <= 1'b0;
      error     <= 1'b0;
    end else begin
      out_nd <= rd_ok;
      if (rd_ok) begin
        out_data  <= in_data;
        out_m     <= ram[{r_bank, raddr}];
        out_first <= (r_addr == '0);
      end
      if ((in_nd && !wr_ok) || (in_data_nd && !rd_ok)) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mdrain.sv
// Scoreboard bench for mdrain (N=8, MWIDTH=4, WIDTH=32).
module tb_mdrain;

  localparam int N = 8;
  localparam int MW = 4;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_nd = 1'b0;
  logic [MW-1:0] in_m = '0;
  logic          in_data_nd = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_nd;
  logic [W-1:0]  out_data;
  logic [MW-1:0] out_m;
  logic          out_first;
  logic          error;

  mdrain #(.N(N), .MWIDTH(MW), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_nd      (in_nd),
    .in_m       (in_m),
    .in_data_nd (in_data_nd),
    .in_data    (in_data),
    .out_nd     (out_nd),
    .out_data   (out_data),
    .out_m      (out_m),
    .out_first  (out_first),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [MW-1:0] m;
    logic          first;
  } exp_t;

  exp_t          sb[$];
  logic [MW-1:0] mem[$];
  int            nfull, wcnt, ridx;
  logic          m_err, exp_nd, chk_en;
  exp_t          last;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int brev3(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) if (v[i]) r = r | (1 << (2 - i));
    return r;
  endfunction

  task automatic model_clear();
    sb.delete();
    mem.delete();
    nfull = 0;
    wcnt = 0;
    ridx = 0;
    m_err = 1'b0;
    exp_nd = 1'b0;
    last = '0;
  endtask

  task automatic drive(input logic wn, input logic [MW-1:0] wm, input logic rn, input logic [W-1:0] rd);
    logic w_ok, r_ok;
    int   ra, inc, dec;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    in_nd = wn; in_m = wm; in_data_nd = rn; in_data = rd;
    w_ok = wn && (nfull < 2);
    r_ok = rn && (nfull >= 1);
    if ((wn && !w_ok) || (rn && !r_ok)) m_err = 1'b1;
    exp_nd = r_ok;
    inc = 0;
    dec = 0;
    if (r_ok) begin
`ifdef MDRAIN_BITREV_EN
      ra = brev3(ridx);
`else
      ra = ridx;
`endif
      e.data = rd;
      e.m = mem[ra];
      e.first = (ridx == 0);
      sb.push_back(e);
    end
    if (w_ok) begin
      mem.push_back(wm);
      wcnt++;
      if (wcnt == N) begin wcnt = 0; inc = 1; end
    end
    if (r_ok) begin
      ridx++;
      if (ridx == N) begin
        ridx = 0;
        dec = 1;
        for (int i = 0; i < N; i++) void'(mem.pop_front());
      end
    end
    nfull = nfull + inc - dec;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_nd = 1'b0; in_data_nd = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_out_nd", out_nd, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_m", out_m, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_error", error, 0);
  endtask

  // Per-cycle output check against the scoreboard
  always begin
    @(posedge clk);
    #1;
    if (chk_en && rst_n) begin
      chk("out_nd", out_nd, exp_nd);
      chk("error", error, m_err);
      if (out_nd) begin
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          last = sb.pop_front();
          chk("out_data", out_data, last.data);
          chk("out_m", out_m, last.m);
          chk("out_first", out_first, last.first);
        end
      end else begin
        chk("hold_data", out_data, last.data);
        chk("hold_m", out_m, last.m);
        chk("hold_first", out_first, last.first);
      end
    end
  end

  initial begin
    model_clear();
    chk_en = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    do_reset();

    // In-order frame: metadata 0..7 then data 100..107
    for (int i = 0; i < N; i++) drive(1'b1, MW'(i), 1'b0, '0);
    for (int i = 0; i < N; i++) drive(1'b0, '0, 1'b1, 32'(100 + i));
    drive(1'b0, '0, 1'b0, '0);

    // Frame A, then B written while A drains, then B drains
    for (int i = 0; i < N; i++) drive(1'b1, MW'(15 - i), 1'b0, '0);
    for (int i = 0; i < N; i++) drive(1'b1, MW'(3 + i), 1'b1, 32'(200 + i));
    for (int i = 0; i < N; i++) drive(1'b0, '0, 1'b1, 32'(300 + i));
    drive(1'b0, '0, 1'b0, '0);

    // Overflow: 17 writes, the last one dropped
    for (int i = 0; i < 2 * N + 1; i++) drive(1'b1, MW'(i * 5), 1'b0, '0);
    for (int i = 0; i < 2 * N; i++) drive(1'b0, '0, 1'b1, 32'(400 + i));
    drive(1'b0, '0, 1'b0, '0);

    // Underflow, then a legal frame
    do_reset();
    drive(1'b0, '0, 1'b1, 32'd55);
    drive(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < N; i++) drive(1'b1, MW'(9 + i), 1'b0, '0);
    for (int i = 0; i < N; i++) drive(1'b0, '0, 1'b1, 32'(500 + i));
    drive(1'b0, '0, 1'b0, '0);

    // Reset mid-frame, then a fresh frame drains from index 0
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, MW'(i + 1), 1'b0, '0);
    do_reset();
    for (int i = 0; i < N; i++) drive(1'b1, MW'(7 - i), 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'd600);
    for (int i = 1; i < N; i++) drive(1'b1, MW'(i), 1'b1, 32'(600 + i));
    drive(1'b0, '0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, '0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
